booth_mac_acc: RTL and testbench
================================

Name: booth_mac_acc

Overview:
- Downstream accumulation stage for the 4x4 signed Booth multiplier.
- Consumes a stream of signed products and sums COUNT consecutive products into one signed result, i.e. one dot-product frame.
- Sits between the registered multiplier output and the result consumer.
- Valid/ready handshake on both input and output, so the consumer can apply backpressure.

Parameters:
- PW, 8, product width in bits; signed two's complement; matches multiplier output.
- AW, 16, accumulator and result width in bits; AW >= PW.
- COUNT, 4, products per frame; COUNT >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous frame abort; clears partial sum.
- in_p  input  PW  signed product from multiplier.
- in_valid  input  1  in_p valid this cycle.
- in_ready  output  1  block accepts in_p this cycle.
- out_sum  output  AW  signed frame sum.
- out_valid  output  1  out_sum valid.
- out_ready  input  1  consumer accepts out_sum.
- ovf  output  1  frame saturated (SATURATE_EN only; otherwise constant 0).

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- States: ACC, HOLD. Reset state ACC.
- Reset values: acc=0, cnt=0, out_sum=0, out_valid=0, ovf=0, state=ACC.
- in_ready=1 iff state==ACC and clr==0; combinational from state and clr.
- Accept = in_valid & in_ready.
- Each accept: acc <= acc + sign_extend(in_p, AW); cnt <= cnt+1.
- Final beat is an accept with cnt==COUNT-1:
  - out_sum <= acc + sign_extend(in_p) (includes this beat); out_valid <= 1.
  - acc <= 0; cnt <= 0; state <= HOLD.
  - Latency: out_valid rises 1 cycle after the final accepted beat.
- HOLD: in_ready=0; out_sum and out_valid held stable until out_ready=1.
  - Cycle with out_valid & out_ready: out_valid <= 0, state <= ACC.
  - in_ready returns to 1 the following cycle; one bubble cycle per frame.
- COUNT==1: every accept is the final beat.
- in_valid=0 in ACC: acc and cnt hold; no timeout.
- Arithmetic without SATURATE_EN: wraps modulo 2^AW; no overflow indication.
- clr=1, priority below rst, above all else:
  - acc=0, cnt=0, out_valid=0, ovf=0, state=ACC.
  - Any input beat that cycle is discarded (in_ready is 0).
  - A pending result in HOLD is dropped; out_sum keeps its last value but is not valid.
- rst mid-frame or in HOLD: all state returns to reset values the next edge; partial sum is lost.
- out_sum changes only on a final-beat edge or rst.

Optional Feature:
- Macro SATURATE_EN.
- Defined: each addition is clamped to [-2^(AW-1), 2^(AW-1)-1].
  - Clamping happens per beat, and on the final beat before loading out_sum.
  - Internal sticky flag sets on any clamp within the frame.
  - ovf is loaded with the sticky flag together with out_sum and held through HOLD.
  - Sticky flag clears on final beat, clr and rst.
- Not defined: wrap-around arithmetic; ovf tied to 0; no saturation logic synthesised.

Test Plan:
- Basic frame, defaults: hold out_ready=1; beats 8'h0A, 8'hFA, 8'h40, 8'hEC (10, -6, 64, -20) on consecutive cycles -> out_sum=16'h0030 (48); out_valid high 1 cycle after the 4th accept; in_ready low that cycle; in_ready high the cycle after.
- Backpressure: complete a frame of four 8'h01 -> out_sum=16'h0004; hold out_ready=0 for 5 cycles -> out_valid stays 1, out_sum stable, in_ready=0 throughout. Raise out_ready -> out_valid drops next cycle. Next frame of four 8'h02 -> 16'h0008.
- Input gaps: same beats as the basic frame, with in_valid=0 for 3 cycles between beats 2 and 3 -> out_sum=16'h0030, unaffected by gaps.
- Wrap/saturate, AW=8: four beats 8'h40 ->
  - without SATURATE_EN: out_sum=8'h00, ovf=0.
  - with SATURATE_EN: out_sum=8'h7F, ovf=1.
  - with SATURATE_EN, four beats 8'hC8 (-56): out_sum=8'h80, ovf=1.
  - next frame of four 8'h01: out_sum=8'h04, ovf=0.
- clr mid-frame: accept 8'h10, 8'h10; pulse clr 1 cycle -> in_ready=0 that cycle. Then four 8'h03 -> out_sum=16'h000C (prior beats discarded).
- Reset in HOLD: complete a frame; hold out_ready=0; pulse rst -> next cycle out_valid=0, out_sum=0, in_ready=1, ovf=0. A fresh frame then accumulates from 0.

Source files
------------

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: sums COUNT signed Booth products into one frame result; valid/ready on both sides.
// Define SATURATE_EN for clamped arithmetic with a sticky per-frame ovf flag (default: wrap, ovf=0).
module booth_mac_acc #(
  parameter int PW    = 8,
  parameter int AW    = 16,
  parameter int COUNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [PW-1:0] in_p,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ovf
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_sum;
  logic          r_out_valid;

  logic [AW-1:0] w_ext;
  logic [AW-1:0] w_sum;
  logic          w_accept;
  logic          w_final;

  assign in_ready  = (r_state == ACC) && !clr;
  assign w_accept  = in_valid && in_ready;
  assign w_final   = w_accept && (r_cnt == LAST);
  assign w_ext     = AW'($signed(in_p));
  assign out_sum   = r_sum;
  assign out_valid = r_out_valid;

`ifdef SATURATE_EN
  localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

  logic [AW:0] w_wide;
  logic        w_clamp;
  logic        r_sticky;
  logic        r_ovf;

  // One guard bit: the two top bits disagree exactly when the signed add overflowed.
  assign w_wide  = {r_acc[AW-1], r_acc} + {w_ext[AW-1], w_ext};
  assign w_clamp = w_wide[AW] ^ w_wide[AW-1];
  assign w_sum   = !w_clamp ? w_wide[AW-1:0] : (w_wide[AW] ? MINV : MAXV);
  assign ovf     = r_ovf;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_final) begin
      r_ovf    <= r_sticky | w_clamp;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sticky <= r_sticky | w_clamp;
    end
  end
`else
  assign w_sum = r_acc + w_ext;
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      // Abort drops any pending result but leaves out_sum at its last value.
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_final) begin
      r_sum       <= w_sum;
      r_out_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_state     <= HOLD;
    end else if (w_accept) begin
      r_acc       <= w_sum;
      r_cnt       <= r_cnt + CW'(1);
    end else if (r_state == HOLD && out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= ACC;
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: one default instance (AW=16) and one AW=8 instance share the stimulus.
module tb_booth_mac_acc;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] in_p;

  logic        rdy16, vld16, ovf16;
  logic [15:0] sum16;
  logic        rdy8, vld8, ovf8;
  logic [7:0]  sum8;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc16, m_acc8, m_cnt;
  bit   m_st16, m_st8;

  always #5 clk = ~clk;

  booth_mac_acc u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_p(in_p), .in_valid(in_valid), .in_ready(rdy16),
    .out_sum(sum16), .out_valid(vld16), .out_ready(out_ready), .ovf(ovf16)
  );

  booth_mac_acc #(.PW(8), .AW(8), .COUNT(4)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_p(in_p), .in_valid(in_valid), .in_ready(rdy8),
    .out_sum(sum8), .out_valid(vld8), .out_ready(out_ready), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int add_w(input int a, input int b, input int aw, output bit clamped);
    int s, hi, lo;
    s  = a + b;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    clamped = 1'b0;
`ifdef SATURATE_EN
    if (s > hi) begin s = hi; clamped = 1'b1; end
    else if (s < lo) begin s = lo; clamped = 1'b1; end
`else
    if (s > hi) s -= (1 << aw);
    else if (s < lo) s += (1 << aw);
`endif
    return s;
  endfunction

  task automatic model_clear();
    m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_st16 = 0; m_st8 = 0;
  endtask

  task automatic model_beat(input logic [7:0] p);
    bit c;
    int v;
    v = int'($signed(p));
    m_acc16 = add_w(m_acc16, v, 16, c); m_st16 |= c;
    m_acc8  = add_w(m_acc8,  v, 8,  c); m_st8  |= c;
    if (m_cnt == 3) begin
      q16.push_back('{sum: 16'(m_acc16 & 'hFFFF), ovf: m_st16});
      q8.push_back('{sum: 16'(m_acc8 & 'hFF), ovf: m_st8});
      model_clear();
    end else begin
      m_cnt++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input logic [7:0] p);
    int n;
    n = 0;
    in_p = p; in_valid = 1'b1; #1;
    while (!rdy16 && n < 20) begin @(posedge clk); #1; n++; end
    chk("beat_in_ready", rdy16, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(p);
  endtask

  task automatic frame4(input logic [7:0] p);
    for (int i = 0; i < 4; i++) drive_beat(p);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vld16 === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (q16.size() > 0) else begin
        errors++;
        $error("FAIL unexpected16: observed sum=%0h expected no result", sum16);
      end
      if (q16.size() > 0) begin
        e = q16.pop_front();
        chk("sum16", sum16, e.sum);
        chk("ovf16", ovf16, e.ovf);
      end
    end
    if (vld8 === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (q8.size() > 0) else begin
        errors++;
        $error("FAIL unexpected8: observed sum=%0h expected no result", sum8);
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("sum8", sum8, e.sum);
        chk("ovf8", ovf8, e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_vld16", vld16, 0); chk("rst_sum16", sum16, 0);
    chk("rst_ovf16", ovf16, 0); chk("rst_rdy16", rdy16, 1);
    chk("rst_vld8", vld8, 0);   chk("rst_sum8", sum8, 0);
    chk("rst_ovf8", ovf8, 0);   chk("rst_rdy8", rdy8, 1);

    // Basic frame: 10 - 6 + 64 - 20 = 48
    out_ready = 1'b1;
    drive_beat(8'h0A); drive_beat(8'hFA); drive_beat(8'h40);
    chk("basic_no_early_vld", vld16, 0);
    drive_beat(8'hEC);
    chk("basic_vld16", vld16, 1); chk("basic_vld8", vld8, 1);
    chk("basic_rdy_low", rdy16, 0);
    idle();
    chk("basic_vld_drop", vld16, 0); chk("basic_rdy_back", rdy16, 1);

    // Backpressure, with an offered beat that must be ignored during HOLD
    out_ready = 1'b0;
    frame4(8'h01);
    in_p = 8'h7F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", vld16, 1); chk("bp_sum", sum16, 16'h0004); chk("bp_rdy", rdy16, 0);
      idle();
    end
    out_ready = 1'b1;
    idle();
    in_valid = 1'b0;
    chk("bp_vld_drop", vld16, 0);
    frame4(8'h02);
    idle();

    // Gaps between beats 2 and 3
    drive_beat(8'h0A); drive_beat(8'hFA);
    repeat (3) idle();
    drive_beat(8'h40); drive_beat(8'hEC);
    idle();

    // Wrap / saturate on the AW=8 instance
    frame4(8'h40);
    frame4(8'hC8);
    frame4(8'h01);
    idle();

    // clr mid-frame discards partial sum and the beat offered that cycle
    drive_beat(8'h10); drive_beat(8'h10);
    clr = 1'b1; in_p = 8'h55; in_valid = 1'b1; #1;
    chk("clr_rdy", rdy16, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    frame4(8'h03);
    idle();

    // Reset while holding a result
    out_ready = 1'b0;
    frame4(8'h05);
    chk("hold_vld", vld16, 1);
    rst = 1'b1;
    q16.delete(); q8.delete(); model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rsthold_vld", vld16, 0); chk("rsthold_sum", sum16, 0);
    chk("rsthold_rdy", rdy16, 1); chk("rsthold_ovf8", ovf8, 0);
    chk("rsthold_sum8", sum8, 0);
    out_ready = 1'b1;
    frame4(8'h07);

    n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 50) begin idle(); n++; end
    chk("drain16", q16.size(), 0);
    chk("drain8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
